// File: rtl/dmem_bus_ctrl_if.sv
// External word-memory bus between the data-memory controller and a
// variable-latency memory: request/ack handshake plus address and data.
interface dmem_bus_ctrl_if;
   logic        ext_req;
   logic        ext_we;
   logic [29:0] ext_addr;
   logic [31:0] ext_wdata;
   logic [31:0] ext_rdata;
   logic        ext_ack;

   modport master (
      output ext_req,
      output ext_we,
      output ext_addr,
      output ext_wdata,
      input  ext_rdata,
      input  ext_ack
   );

   modport slave (
      input  ext_req,
      input  ext_we,
      input  ext_addr,
      input  ext_wdata,
      output ext_rdata,
      output ext_ack
   );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns memory-stage loads/stores into req/ack
// transactions, stalling the single-cycle core until each one completes.
module dmem_bus_ctrl #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] BAD_DATA       = 32'hDEADBEEF
) (
   input  logic                  CLK,
   input  logic                  Reset_L,
   input  logic [31:0]           Addr,
   input  logic [31:0]           WriteData,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   output logic [31:0]           ReadData,
   output logic                  Stall,
   output logic                  AddrError,
   output logic                  TimeoutErr,
   dmem_bus_ctrl_if.master       ext
);

   localparam int                CNT_W        = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic             access;
   logic             aligned;
   logic             launch;
   logic             misaligned;
   logic             finish_ack;
   logic             finish_timeout;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cycle events; an ack on the timeout edge still wins.
   always_comb begin
      state_next     = state;
      launch         = 1'b0;
      misaligned     = 1'b0;
      finish_ack     = 1'b0;
      finish_timeout = 1'b0;
      access         = MemRead | MemWrite;
      aligned        = (Addr[1:0] == 2'b00);

      case (state)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  launch     = 1'b1;
                  state_next = BUSY;
               end else begin
                  misaligned = 1'b1;
               end
            end
         end
         BUSY: begin
            if (ext.ext_ack) begin
               finish_ack = 1'b1;
               state_next = DONE;
            end else if (count == TIMEOUT_LAST) begin
               finish_timeout = 1'b1;
               state_next     = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Gated by reset so the core is released the instant reset asserts.
      Stall = Reset_L & access & aligned & (state != DONE);
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         ReadData      <= 32'h0;
         AddrError     <= 1'b0;
         TimeoutErr    <= 1'b0;
         count         <= '0;
         ext.ext_req   <= 1'b0;
         ext.ext_we    <= 1'b0;
         ext.ext_addr  <= 30'h0;
         ext.ext_wdata <= 32'h0;
      end else begin
         AddrError <= misaligned;

         if (launch) begin
            ext.ext_addr  <= Addr[31:2];
            ext.ext_wdata <= WriteData;
            ext.ext_we    <= MemWrite;
            ext.ext_req   <= 1'b1;
            count         <= '0;
         end

         if (state == BUSY) begin
            count <= count + CNT_W'(1);
         end

         if (finish_ack) begin
            ext.ext_req <= 1'b0;
            if (!ext.ext_we) begin
               ReadData <= ext.ext_rdata;
            end
         end

         if (finish_timeout) begin
            ext.ext_req <= 1'b0;
            TimeoutErr  <= 1'b1;
            if (!ext.ext_we) begin
               ReadData <= BAD_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed scenarios plus random
// loads/stores scored against a transaction-level memory model.
module tb_dmem_bus_ctrl;

   localparam int          TIMEOUT_CYCLES = 64;
   localparam logic [31:0] BAD_DATA       = 32'hDEADBEEF;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        Stall;
   logic        AddrError;
   logic        TimeoutErr;

   dmem_bus_ctrl_if bus ();

   dmem_bus_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .BAD_DATA      (BAD_DATA)
   ) dut (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .Addr      (Addr),
      .WriteData (WriteData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .ReadData  (ReadData),
      .Stall     (Stall),
      .AddrError (AddrError),
      .TimeoutErr(TimeoutErr),
      .ext       (bus.master)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [0:15];
   logic [31:0] exp_rd;
   logic        exp_to;
   int          checks;
   int          errors;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // One instruction's memory access; lat = BUSY cycle carrying the ack, 0 = never ack.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                                input logic rd, input logic wr, input int lat);
      logic       is_access;
      logic       misal;
      logic       timed_out;
      logic       req_bad;
      logic [3:0] widx;
      int         c;
      int         exp_busy;

      is_access = rd | wr;
      misal     = is_access && (a[1:0] != 2'b00);
      widx      = a[5:2];

      @(negedge CLK);
      Addr      = a;
      WriteData = wd;
      MemRead   = rd;
      MemWrite  = wr;
      #1;

      if (!is_access || misal) begin
         checkOutput("idle_stall", 32'(Stall), 32'd0);
         @(negedge CLK);
         #1;
         checkOutput("addr_err", 32'(AddrError), 32'(misal));
         checkOutput("no_req", 32'(bus.ext_req), 32'd0);
         checkOutput("stall_low", 32'(Stall), 32'd0);
         checkOutput("rdata_keep", ReadData, exp_rd);
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         if (misal) begin
            @(negedge CLK);
            #1;
            checkOutput("addr_err_drop", 32'(AddrError), 32'd0);
         end
         return;
      end

      timed_out = (lat == 0) || (lat > TIMEOUT_CYCLES);
      exp_busy  = timed_out ? TIMEOUT_CYCLES : lat;
      c         = 0;
      req_bad   = 1'b0;

      while (Stall && c < 200) begin
         if (c == 1) begin
            checkOutput("ext_addr", 32'(bus.ext_addr), 32'(a[31:2]));
            checkOutput("ext_we", 32'(bus.ext_we), 32'(wr));
            checkOutput("ext_wdata", bus.ext_wdata, wd);
         end
         if (c >= 1 && bus.ext_req !== 1'b1) req_bad = 1'b1;
         bus.ext_ack   = (lat != 0) && (c == lat);
         bus.ext_rdata = bus.ext_ack ? mem[widx] : $urandom;
         @(negedge CLK);
         bus.ext_ack = 1'b0;
         #1;
         c++;
      end

      if (wr) begin
         if (!timed_out) mem[widx] = wd;
      end else begin
         exp_rd = timed_out ? BAD_DATA : mem[widx];
      end
      exp_to = exp_to | timed_out;

      checkOutput("stall_cycles", 32'(c), 32'(1 + exp_busy));
      checkOutput("req_held", 32'(req_bad), 32'd0);
      checkOutput("req_dropped", 32'(bus.ext_req), 32'd0);
      checkOutput("read_data", ReadData, exp_rd);
      checkOutput("timeout_err", 32'(TimeoutErr), 32'(exp_to));
      checkOutput("done_addr_err", 32'(AddrError), 32'd0);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
   endtask

   // Ack strobe while no transaction is outstanding.
   task automatic strayAck();
      @(negedge CLK);
      bus.ext_ack   = 1'b1;
      bus.ext_rdata = $urandom;
      @(negedge CLK);
      bus.ext_ack = 1'b0;
      #1;
      checkOutput("stray_rdata", ReadData, exp_rd);
      checkOutput("stray_req", 32'(bus.ext_req), 32'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic        rrd;
      logic        rwr;
      int          kind;
      int          rlat;

      checks        = 0;
      errors        = 0;
      exp_rd        = 32'h0;
      exp_to        = 1'b0;
      Reset_L       = 1'b1;
      Addr          = 32'h0;
      WriteData     = 32'h0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      bus.ext_ack   = 1'b0;
      bus.ext_rdata = 32'h0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[4] = 32'h1234_5678;

      #2 Reset_L = 1'b0;
      repeat (2) @(negedge CLK);
      #1;
      checkOutput("rst_rdata", ReadData, 32'h0);
      checkOutput("rst_stall", 32'(Stall), 32'd0);
      checkOutput("rst_addr_err", 32'(AddrError), 32'd0);
      checkOutput("rst_timeout", 32'(TimeoutErr), 32'd0);
      checkOutput("rst_req", 32'(bus.ext_req), 32'd0);
      checkOutput("rst_we", 32'(bus.ext_we), 32'd0);
      checkOutput("rst_addr", 32'(bus.ext_addr), 32'd0);
      checkOutput("rst_wdata", bus.ext_wdata, 32'h0);
      @(negedge CLK);
      Reset_L = 1'b1;

      $display("[TB] directed scenarios");
      applyStimulus(32'h0000_0010, 32'h0, 1'b1, 1'b0, 3);
      applyStimulus(32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b1, 1);
      applyStimulus(32'h0000_0013, 32'h0, 1'b1, 1'b0, 1);
      strayAck();
      applyStimulus(32'h0000_0030, 32'h0, 1'b1, 1'b0, 0);
      applyStimulus(32'h0000_0020, 32'h0, 1'b1, 1'b0, 2);
      applyStimulus(32'h0000_0008, 32'h0, 1'b1, 1'b0, TIMEOUT_CYCLES);

      $display("[TB] reset during BUSY");
      @(negedge CLK);
      Addr      = 32'h0000_0028;
      WriteData = 32'h5A5A_1234;
      MemRead   = 1'b1;
      MemWrite  = 1'b0;
      repeat (3) @(negedge CLK);
      #2 Reset_L = 1'b0;
      #1;
      exp_rd = 32'h0;
      exp_to = 1'b0;
      checkOutput("mid_rst_req", 32'(bus.ext_req), 32'd0);
      checkOutput("mid_rst_stall", 32'(Stall), 32'd0);
      checkOutput("mid_rst_rdata", ReadData, 32'h0);
      checkOutput("mid_rst_timeout", 32'(TimeoutErr), 32'd0);
      checkOutput("mid_rst_addr", 32'(bus.ext_addr), 32'd0);
      checkOutput("mid_rst_wdata", bus.ext_wdata, 32'h0);
      @(negedge CLK);
      Reset_L = 1'b1;
      MemRead = 1'b0;
      strayAck();
      applyStimulus(32'h0000_0010, 32'h0, 1'b1, 1'b0, 2);

      $display("[TB] back-to-back loads");
      applyStimulus(32'h0000_0000, 32'h0, 1'b1, 1'b0, 1);
      applyStimulus(32'h0000_0004, 32'h0, 1'b1, 1'b0, 1);

      $display("[TB] random traffic");
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         ra   = {$urandom} & 32'hFFFF_FFFC;
         rrd  = 1'b0;
         rwr  = 1'b0;
         rlat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
         if (kind == 1) begin
            ra[1:0] = 2'($urandom_range(1, 3));
            rrd     = 1'b1;
            rwr     = 1'($urandom_range(0, 1));
         end else if (kind >= 2) begin
            rwr = 1'($urandom_range(0, 1));
            rrd = rwr ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         applyStimulus(ra, $urandom, rrd, rwr, rlat);
         if ($urandom_range(0, 3) == 0) strayAck();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
